// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a valid/ready handshake and a kill input for pipeline flushes.
module muldiv_iter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         kill,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int unsigned CW = $clog2(N + 1);

  state_t          state, state_nxt;
  logic [2:0]      op_r;
  logic            sa_r, sb_r;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    opnd;
  logic [CW-1:0]   cnt;

  logic            sign_a, sign_b, is_div, div0, ovf, special;
  logic [N-1:0]    a_mag, b_mag, special_res;
  logic [N:0]      sum, shifted, diff;
  logic [2*N-1:0]  mul_step, div_step, step, step_neg, mul_fin;
  logic [N-1:0]    q, r, q_neg, r_neg, mul_res, div_res, fin_res;

  // Operand conditioning at accept: signed ops are reduced to magnitudes.
  always_comb begin
    sign_a = ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110)) && A[N-1];
    sign_b = ((op == 3'b001) || (op == 3'b100) || (op == 3'b110)) && B[N-1];
    a_mag  = sign_a ? -A : A;
    b_mag  = sign_b ? -B : B;
    is_div = op[2];
    div0   = is_div && (B == '0);
    ovf    = is_div && !op[0] && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
    special = div0 || ovf;
    if (div0) special_res = op[1] ? A : '1;
    else      special_res = op[1] ? '0 : A;
  end

  // prod holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    sum      = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_step = {sum, prod[N-1:1]};
    shifted  = {prod[2*N-1:N], prod[N-1]};
    diff     = shifted - {1'b0, opnd};
    div_step = diff[N] ? {shifted[N-1:0], prod[N-2:0], 1'b0}
                       : {diff[N-1:0],    prod[N-2:0], 1'b1};
    step     = op_r[2] ? div_step : mul_step;
    step_neg = -step;
    mul_fin  = (sa_r ^ sb_r) ? step_neg : step;
    mul_res  = (op_r[1:0] == 2'b00) ? mul_fin[N-1:0] : mul_fin[2*N-1:N];
    q        = step[N-1:0];
    r        = step[2*N-1:N];
    q_neg    = -q;
    r_neg    = -r;
    div_res  = op_r[1] ? (sa_r ? r_neg : r) : ((sa_r ^ sb_r) ? q_neg : q);
    fin_res  = op_r[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid && !kill) state_nxt = special ? DONE : BUSY;
      BUSY: if (kill) state_nxt = IDLE;
            else if (cnt == CW'(1)) state_nxt = DONE;
      DONE: if (kill || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r   <= '0;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      prod   <= '0;
      opnd   <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_r <= op;
          sa_r <= sign_a;
          sb_r <= sign_b;
          prod <= {{N{1'b0}}, (is_div ? a_mag : b_mag)};
          opnd <= is_div ? b_mag : a_mag;
          if (special) begin
            result <= special_res;
            cnt    <= '0;
          end else begin
            cnt    <= CW'(N);
          end
        end
        BUSY: begin
          prod <= step;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) result <= fin_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed vectors push expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  muldiv_iter #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on any cycle where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else begin
        chk(name_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  // Waits for in_ready, presents the request, returns right after the accepting edge.
  task automatic drive_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = ~o; A = ~a; B = b + 32'd1;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int cycles = 0;
    bit seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
      @(posedge clk);
      cycles++;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    else       chk({name, "_latency"}, 32'(cycles), 32'(exp_lat));
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    exp_q.push_back(exp);
    name_q.push_back(name);
    drive_req(o, a, b);
    wait_valid(name, exp_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stray;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    run_op("mulhu_ff",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
    run_op("mul_ff",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    run_op("mulh_ff",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32);
    run_op("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
    run_op("mulh_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32);
    run_op("mul_shift", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 32);
    run_op("div_neg7",  3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32);
    run_op("rem_neg7",  3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32);
    run_op("div_7_m2",  3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32);
    run_op("rem_7_m2",  3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32);
    run_op("divu_100",  3'b101, 32'd100, 32'd7, 32'd14, 32);
    run_op("remu_100",  3'b111, 32'd100, 32'd7, 32'd2, 32);
    run_op("div_min_1", 3'b100, 32'h80000000, 32'h00000001, 32'h80000000, 32);
    run_op("divu_by0",  3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    run_op("remu_by0",  3'b111, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

    // Backpressure: result held, new requests ignored while DONE.
    out_ready = 1'b0;
    exp_q.push_back(32'hFFFFFFFE);
    name_q.push_back("bp_result");
    drive_req(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid("bp", 32);
    @(posedge clk);
    #1;
    in_valid = 1'b1; op = 3'b000; A = 32'd3; B = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", result, 32'hFFFFFFFE);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Kill during the 10th busy cycle of a DIVU.
    drive_req(3'b101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray = 1;
    end
    chk("kill_no_valid", {31'd0, stray}, 32'd0);
    run_op("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, 32);

    // Reset at the 5th busy cycle of a MUL.
    drive_req(3'b000, 32'd5, 32'd7);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    run_op("remu_after_rst", 3'b111, 32'h12345678, 32'h00000100, 32'h00000078, 32);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
